vram_line_painter: RTL and testbench
====================================

# vram_line_painter

Pen-stroke rasterizer between the FT6206 touch controller and the video RAM write port. It clears VRAM to a background colour after reset or on request. It then converts successive valid touch samples into connected strokes by drawing a Bresenham line from the previous pen position to each new one. It writes one pixel per cycle into the single-port write side of `block_ram`; the display controller reads the other side.

## Interface
Parameters:
- `DISPLAY_WIDTH`, 240, pixels per row (x range).
- `DISPLAY_HEIGHT`, 320, rows (y range).
- `VRAM_L`, localparam `DISPLAY_WIDTH*DISPLAY_HEIGHT`, number of pixel words.
- `VRAM_W`, 16, colour word width (RGB565).
- `FG_COLOR`, 16'hFD20 (orange), stroke colour.
- `BG_COLOR`, 16'h000F (navy), clear colour.

Ports:
- `clk` in 1: single system clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ena` in 1: when low, new touch samples are not accepted. An in-progress line or clear still completes.
- `touch_valid` in 1: touch sample is valid (finger down).
- `touch_x` in 9: touch column, unsigned.
- `touch_y` in 9: touch row, unsigned.
- `clear_req` in 1: single-cycle pulse requesting a full-screen clear.
- `vram_wr_ena` out 1: VRAM write strobe.
- `vram_wr_addr` out `$clog2(VRAM_L)`: write address, `y*DISPLAY_WIDTH + x`.
- `vram_wr_data` out `VRAM_W`: write colour.
- `busy` out 1: high in CLEAR and LINE states.

## Operation
- States are CLEAR, IDLE and LINE. The pen state is `pen_down` plus a last point `(lx, ly)`.
- Reset sets state CLEAR, clear counter 0, `pen_down` 0, `lx`/`ly` 0 and the pending-clear flag 0. All outputs are registered and reset to 0.

CLEAR:
- Writes `BG_COLOR` to addresses 0 through `VRAM_L-1`, one per cycle, in ascending order. That is exactly `VRAM_L` writes, with no write at address `VRAM_L`.
- After the last write, the state goes to IDLE and `pen_down` is cleared.

IDLE:
- `vram_wr_ena` is 0.
- Priority order:
  1. If a clear is pending, clear the flag, reset the counter and go to CLEAR.
  2. If `ena && touch_valid`, accept the sample.
  3. If `!touch_valid`, set `pen_down` to 0.
- Accepted coordinates are clamped first: `x = min(touch_x, DISPLAY_WIDTH-1)` and `y = min(touch_y, DISPLAY_HEIGHT-1)`.
- If `pen_down` is 0, start a line from (x,y) to (x,y), i.e. a single dot.
- If `pen_down` is 1 and (x,y) ≠ (lx,ly), start a line from (lx,ly) to (x,y).
- If `pen_down` is 1 and (x,y) = (lx,ly), write nothing and stay in IDLE.
- On starting a line, set `pen_down` to 1 and (lx,ly) to (x,y), then go to LINE.

LINE (Bresenham):
- Setup:
  - `dx = |x1-x0|`, `dy = -|y1-y0|`.
  - `sx`/`sy` = ±1 toward the endpoint.
  - `err = dx + dy`, held as 12-bit signed. dx, dy and err are signed 12-bit; no overflow is possible for 9-bit coordinates.
- Each cycle:
  - Write `FG_COLOR` at the current point.
  - If the current point equals the endpoint, go to IDLE.
  - Otherwise compute `e2 = 2*err`.
  - If `e2 >= dy`, then `err += dy` and `x += sx`.
  - If `e2 <= dx`, then `err += dx` and `y += sy`.
- Both endpoints are drawn. The pixel count is `L = max(|x1-x0|, |y1-y0|) + 1`.
- Touch input is ignored during LINE and CLEAR.

`clear_req`:
- A pulse in any state sets the sticky pending flag.
- The clear takes effect on the next IDLE cycle.
- A `clear_req` during CLEAR is also latched and causes a second full clear.

Reset mid-operation:
- Reset aborts any state immediately and restarts CLEAR from address 0.

## Timing
- A sample accepted in IDLE at cycle N puts the first pixel write (`vram_wr_ena`=1) on cycle N+1.
- The writes occupy cycles N+1 through N+L contiguously, and the state is IDLE at N+L+1.
- There is a minimum of one IDLE cycle between consecutive lines.
- `busy` is high exactly on cycles where the state is CLEAR or LINE.
- Clear duration:
  - After reset deasserts at cycle 0, writes occur on cycles 1 through `VRAM_L`.
  - The state is IDLE on cycle `VRAM_L+1`.
- `vram_wr_addr` and `vram_wr_data` are valid whenever `vram_wr_ena`=1. They are don't-care otherwise but must hold their last value.
- Address arithmetic is computed at `$clog2(VRAM_L)` width (17 bits at default parameters). The registered multiply-add must meet the clock with one cycle of output latency; this is already counted in the N+1 figure above.

## Test plan
- Reset then idle:
  - Required: exactly 76800 writes of 16'h000F to addresses 0..76799 in order.
  - Required: `busy` falls on cycle 76801.
  - Required: no write to address 76800.
- Single tap (valid for 1 cycle at x=10, y=20, after clear):
  - Required: one write of `FG_COLOR` to address 4810.
  - Required: `pen_down` clears when valid drops.
- Stroke from (0,0) to (5,0) (two samples, valid held):
  - Required: a dot at address 0.
  - Required: then 6 writes at addresses 0..5 on consecutive cycles.
- Diagonal from (3,3) to (0,6):
  - Required: 4 writes at (3,3), (2,4), (1,5), (0,6), i.e. addresses 723, 962, 1201, 1440.
- Clamp and duplicate:
  - Stimulus: touch (300,400) then the same sample held.
  - Required: one write at address 76799, then no further writes.
- `clear_req` during a 100-pixel line:
  - Required: all 100 line writes complete.
  - Required: one IDLE cycle, then a full 76800-write clear.
  - Required: the next touch draws a dot, not a line.

Source files
------------

// File: rtl/vram_line_painter.sv
// Touch-to-VRAM pen rasterizer: full-screen clear, then Bresenham strokes between successive touch samples.
// One pixel written per cycle; all outputs registered.
module vram_line_painter #(
  parameter int DISPLAY_WIDTH  = 240,
  parameter int DISPLAY_HEIGHT = 320,
  parameter int VRAM_W         = 16,
  parameter logic [VRAM_W-1:0] FG_COLOR = VRAM_W'(16'hFD20),
  parameter logic [VRAM_W-1:0] BG_COLOR = VRAM_W'(16'h000F)
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           ena,
  input  logic                                           touch_valid,
  input  logic [8:0]                                     touch_x,
  input  logic [8:0]                                     touch_y,
  input  logic                                           clear_req,
  output logic                                           vram_wr_ena,
  output logic [$clog2(DISPLAY_WIDTH*DISPLAY_HEIGHT)-1:0] vram_wr_addr,
  output logic [VRAM_W-1:0]                              vram_wr_data,
  output logic                                           busy
);

  localparam int VRAM_L = DISPLAY_WIDTH * DISPLAY_HEIGHT;
  localparam int ADDR_W = $clog2(VRAM_L);
  localparam int CNT_W  = $clog2(VRAM_L + 1);
  localparam logic [8:0]        X_MAX      = 9'(DISPLAY_WIDTH - 1);
  localparam logic [8:0]        Y_MAX      = 9'(DISPLAY_HEIGHT - 1);
  localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(DISPLAY_WIDTH);
  localparam logic [CNT_W-1:0]  CLR_END    = CNT_W'(VRAM_L);

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_LINE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   clr_cnt;
  logic               clr_pend;
  logic               pen_down;
  logic [8:0]         lx, ly;
  logic [8:0]         cx, cy;
  logic [8:0]         ex, ey;
  logic               x_neg, y_neg;
  logic signed [11:0] dx, dy, err;

  logic [8:0]         tx, ty, x0, y0;
  logic signed [11:0] x_diff, y_diff, dx0, dy0;
  logic signed [12:0] e2, dx13, dy13;
  logic               dup, at_end, step_x, step_y;
  logic [8:0]         nx, ny;
  logic signed [11:0] nerr;

  function automatic logic [ADDR_W-1:0] pix_addr(input logic [8:0] x, input logic [8:0] y);
    return ADDR_W'(y) * ROW_STRIDE + ADDR_W'(x);
  endfunction

  // Line setup from the clamped sample, plus one Bresenham step of the active line.
  always_comb begin
    tx     = (touch_x > X_MAX) ? X_MAX : touch_x;
    ty     = (touch_y > Y_MAX) ? Y_MAX : touch_y;
    x0     = pen_down ? lx : tx;
    y0     = pen_down ? ly : ty;
    x_diff = $signed({3'b000, tx}) - $signed({3'b000, x0});
    y_diff = $signed({3'b000, ty}) - $signed({3'b000, y0});
    dx0    = x_diff[11] ? -x_diff : x_diff;
    dy0    = y_diff[11] ? y_diff : -y_diff;
    dup    = pen_down && (tx == lx) && (ty == ly);

    at_end = (cx == ex) && (cy == ey);
    e2     = {err, 1'b0};
    dx13   = {dx[11], dx};
    dy13   = {dy[11], dy};
    step_x = (e2 >= dy13);
    step_y = (e2 <= dx13);
    nerr   = err;
    nx     = cx;
    ny     = cy;
    if (step_x) begin
      nerr = nerr + dy;
      nx   = x_neg ? cx - 9'd1 : cx + 9'd1;
    end
    if (step_y) begin
      nerr = nerr + dx;
      ny   = y_neg ? cy - 9'd1 : cy + 9'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_CLEAR;
      clr_cnt      <= '0;
      clr_pend     <= 1'b0;
      pen_down     <= 1'b0;
      lx           <= '0;
      ly           <= '0;
      cx           <= '0;
      cy           <= '0;
      ex           <= '0;
      ey           <= '0;
      x_neg        <= 1'b0;
      y_neg        <= 1'b0;
      dx           <= '0;
      dy           <= '0;
      err          <= '0;
      vram_wr_ena  <= 1'b0;
      vram_wr_addr <= '0;
      vram_wr_data <= '0;
      busy         <= 1'b0;
    end else begin
      if (clear_req) clr_pend <= 1'b1;
      case (state)
        S_CLEAR: begin
          if (clr_cnt == CLR_END) begin
            state       <= S_IDLE;
            pen_down    <= 1'b0;
            vram_wr_ena <= 1'b0;
            busy        <= 1'b0;
          end else begin
            vram_wr_ena  <= 1'b1;
            vram_wr_addr <= clr_cnt[ADDR_W-1:0];
            vram_wr_data <= BG_COLOR;
            clr_cnt      <= clr_cnt + CNT_W'(1);
            busy         <= 1'b1;
          end
        end
        S_IDLE: begin
          vram_wr_ena <= 1'b0;
          if (clr_pend) begin
            // A request arriving on this very cycle must survive into the next clear.
            clr_pend <= clear_req;
            clr_cnt  <= '0;
            state    <= S_CLEAR;
            busy     <= 1'b1;
          end else if (ena && touch_valid) begin
            if (!dup) begin
              state        <= S_LINE;
              pen_down     <= 1'b1;
              lx           <= tx;
              ly           <= ty;
              cx           <= x0;
              cy           <= y0;
              ex           <= tx;
              ey           <= ty;
              dx           <= dx0;
              dy           <= dy0;
              err          <= dx0 + dy0;
              x_neg        <= x_diff[11];
              y_neg        <= y_diff[11];
              vram_wr_ena  <= 1'b1;
              vram_wr_addr <= pix_addr(x0, y0);
              vram_wr_data <= FG_COLOR;
              busy         <= 1'b1;
            end
          end else if (!touch_valid) begin
            pen_down <= 1'b0;
          end
        end
        S_LINE: begin
          if (at_end) begin
            state       <= S_IDLE;
            vram_wr_ena <= 1'b0;
            busy        <= 1'b0;
          end else begin
            cx           <= nx;
            cy           <= ny;
            err          <= nerr;
            vram_wr_ena  <= 1'b1;
            vram_wr_addr <= pix_addr(nx, ny);
          end
        end
        default: state <= S_CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_line_painter.sv
// Bench for vram_line_painter: transaction-level pen model plus integer Bresenham reference.
module tb_vram_line_painter;

  // Reduced height keeps each full-screen clear short; row stride stays at 240.
  localparam int W  = 240;
  localparam int H  = 24;
  localparam int VL = W * H;
  localparam int AW = $clog2(VL);
  localparam logic [15:0] FG = 16'hFD20;
  localparam logic [15:0] BG = 16'h000F;

  logic          clk = 1'b0;
  logic          rst, ena, touch_valid, clear_req;
  logic [8:0]    touch_x, touch_y;
  logic          vram_wr_ena, busy;
  logic [AW-1:0] vram_wr_addr;
  logic [15:0]   vram_wr_data;

  int total = 0;
  int bad   = 0;
  bit pen   = 1'b0;
  int lx = 0, ly = 0;
  int exp_q[$];
  int seen[$];

  vram_line_painter #(.DISPLAY_WIDTH(W), .DISPLAY_HEIGHT(H)) dut (
    .clk(clk), .rst(rst), .ena(ena), .touch_valid(touch_valid),
    .touch_x(touch_x), .touch_y(touch_y), .clear_req(clear_req),
    .vram_wr_ena(vram_wr_ena), .vram_wr_addr(vram_wr_addr),
    .vram_wr_data(vram_wr_data), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic void model_line(int x0, int y0, int x1, int y1);
    int ddx, ddy, sx, sy, err, e2;
    ddx = (x1 > x0) ? x1 - x0 : x0 - x1;
    ddy = (y1 > y0) ? y0 - y1 : y1 - y0;
    sx  = (x0 < x1) ? 1 : -1;
    sy  = (y0 < y1) ? 1 : -1;
    err = ddx + ddy;
    for (int n = 0; n < 2000; n++) begin
      exp_q.push_back(y0 * W + x0);
      if (x0 == x1 && y0 == y1) break;
      e2 = 2 * err;
      if (e2 >= ddy) begin err += ddy; x0 += sx; end
      if (e2 <= ddx) begin err += ddx; y0 += sy; end
    end
  endfunction

  // Present one sample in an IDLE cycle and check the resulting pixel burst and return to IDLE.
  task automatic send(input string nm, input int x, input int y, input bit v, input bit e);
    int cxm, cym;
    exp_q.delete();
    seen.delete();
    touch_x = 9'(x); touch_y = 9'(y); touch_valid = v; ena = e;
    cxm = (x > W - 1) ? W - 1 : x;
    cym = (y > H - 1) ? H - 1 : y;
    if (v && e) begin
      if (!pen || cxm != lx || cym != ly) begin
        if (pen) model_line(lx, ly, cxm, cym);
        else     model_line(cxm, cym, cxm, cym);
        pen = 1'b1; lx = cxm; ly = cym;
      end
    end else if (!v) begin
      pen = 1'b0;
    end
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clk);
      if (vram_wr_ena) seen.push_back(int'(vram_wr_addr));
      total++;
      if (vram_wr_ena !== 1'b1 || vram_wr_addr !== AW'(exp_q[k]) || vram_wr_data !== FG || busy !== 1'b1) begin
        bad++;
        $display("FAIL %s px%0d: got ena=%b addr=%0d data=%h busy=%b, want ena=1 addr=%0d data=%h busy=1",
                 nm, k, vram_wr_ena, vram_wr_addr, vram_wr_data, busy, exp_q[k], FG);
      end
    end
    @(negedge clk);
    total++;
    if (vram_wr_ena !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s idle: got ena=%b busy=%b, want ena=0 busy=0", nm, vram_wr_ena, busy);
    end
  endtask

  // Called at the negedge of the cycle the clear state is entered; checks all writes and the IDLE cycle after.
  task automatic run_clear_check(input string nm, input int pulse_at);
    int errs, first, got_a, got_e;
    errs = 0; first = -1; got_a = 0; got_e = 0;
    for (int i = 0; i < VL; i++) begin
      @(negedge clk);
      if (vram_wr_ena !== 1'b1 || vram_wr_addr !== AW'(i) || vram_wr_data !== BG || busy !== 1'b1) begin
        errs++;
        if (first < 0) begin first = i; got_a = int'(vram_wr_addr); got_e = int'(vram_wr_ena); end
      end
      clear_req = (i == pulse_at);
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL %s writes: %0d bad cycles, first at %0d got ena=%0d addr=%0d, want ena=1 addr=%0d data=%h",
               nm, errs, first, got_e, got_a, first, BG);
    end
    @(negedge clk);
    clear_req = 1'b0;
    total++;
    if (vram_wr_ena !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s end: got ena=%b busy=%b, want ena=0 busy=0", nm, vram_wr_ena, busy);
    end
    pen = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ena = 1'b0; touch_valid = 1'b0; touch_x = '0; touch_y = '0; clear_req = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (vram_wr_ena !== 1'b0 || busy !== 1'b0 || vram_wr_addr !== '0 || vram_wr_data !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got ena=%b busy=%b addr=%0d data=%h, want all 0",
               vram_wr_ena, busy, vram_wr_addr, vram_wr_data);
    end
    rst = 1'b0;
    run_clear_check("boot_clear", -1);
  endtask

  task automatic test_tap();
    send("tap_lift0", 0, 0, 1'b0, 1'b1);
    send("tap", 10, 20, 1'b1, 1'b1);
    total++;
    if (seen.size() != 1 || seen[0] != 4810) begin
      bad++; $display("FAIL tap_addr: got %0d writes first=%0d, want 1 write at 4810", seen.size(), (seen.size() > 0) ? seen[0] : -1);
    end
    send("tap_lift", 10, 20, 1'b0, 1'b1);
    send("tap2", 12, 20, 1'b1, 1'b1);
    total++;
    if (seen.size() != 1 || seen[0] != 4812) begin
      bad++; $display("FAIL tap_pen_up: got %0d writes, want single dot at 4812", seen.size());
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    send("b2b_lift", 0, 0, 1'b0, 1'b1);
    send("b2b_dot", 0, 0, 1'b1, 1'b1);
    total++;
    if (seen.size() != 1 || seen[0] != 0) begin
      bad++; $display("FAIL b2b_dot: got %0d writes, want one write at 0", seen.size());
    end
    send("b2b_line", 5, 0, 1'b1, 1'b1);
    ok = (seen.size() == 6);
    for (int i = 0; i < seen.size(); i++) if (seen[i] != i) ok = 1'b0;
    total++;
    if (!ok) begin
      bad++; $display("FAIL b2b_line: got %0d writes, want addresses 0..5", seen.size());
    end
  endtask

  task automatic test_diagonal();
    int d[4];
    bit ok;
    d = '{723, 962, 1201, 1440};
    send("diag_lift", 3, 3, 1'b0, 1'b1);
    send("diag_dot", 3, 3, 1'b1, 1'b1);
    send("diag", 0, 6, 1'b1, 1'b1);
    ok = (seen.size() == 4);
    for (int i = 0; i < 4 && i < seen.size(); i++) if (seen[i] != d[i]) ok = 1'b0;
    total++;
    if (!ok) begin
      bad++; $display("FAIL diag_addrs: got %0d writes, want 723 962 1201 1440", seen.size());
    end
  endtask

  task automatic test_clamp_dup();
    send("clamp_lift", 0, 0, 1'b0, 1'b1);
    send("clamp", 300, 400, 1'b1, 1'b1);
    total++;
    if (seen.size() != 1 || seen[0] != VL - 1) begin
      bad++; $display("FAIL clamp_addr: got %0d writes, want one write at %0d", seen.size(), VL - 1);
    end
    send("dup1", 300, 400, 1'b1, 1'b1);
    send("dup2", 260, 330, 1'b1, 1'b1);
    total++;
    if (seen.size() != 0) begin
      bad++; $display("FAIL dup_nowrite: got %0d writes, want 0", seen.size());
    end
    send("ena_low", 5, 5, 1'b1, 1'b0);
  endtask

  task automatic test_clear_during_line();
    send("cl_lift", 0, 5, 1'b0, 1'b1);
    send("cl_dot", 0, 5, 1'b1, 1'b1);
    exp_q.delete();
    model_line(0, 5, 99, 5);
    touch_x = 9'd99; touch_y = 9'd5; touch_valid = 1'b1; ena = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      total++;
      if (vram_wr_ena !== 1'b1 || vram_wr_addr !== AW'(exp_q[k]) || vram_wr_data !== FG) begin
        bad++;
        $display("FAIL cl_line px%0d: got ena=%b addr=%0d data=%h, want ena=1 addr=%0d data=%h",
                 k, vram_wr_ena, vram_wr_addr, vram_wr_data, exp_q[k], FG);
      end
      clear_req = (k == 1);
      if (k == 1) touch_valid = 1'b0;
    end
    @(negedge clk);
    total++;
    if (vram_wr_ena !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL cl_gap: got ena=%b busy=%b, want ena=0 busy=0", vram_wr_ena, busy);
    end
    @(negedge clk);
    total++;
    if (vram_wr_ena !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL cl_enter: got ena=%b busy=%b, want ena=0 busy=1", vram_wr_ena, busy);
    end
    run_clear_check("cl_clear", -1);
    send("cl_after", 50, 10, 1'b1, 1'b1);
    total++;
    if (seen.size() != 1 || seen[0] != 2450) begin
      bad++; $display("FAIL cl_after_dot: got %0d writes, want single dot at 2450", seen.size());
    end
  endtask

  task automatic test_double_clear();
    touch_valid = 1'b0;
    clear_req = 1'b1;
    pen = 1'b0;
    @(negedge clk);
    clear_req = 1'b0;
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL dc_idle: got busy=%b, want 0", busy);
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b1 || vram_wr_ena !== 1'b0) begin
      bad++; $display("FAIL dc_enter1: got busy=%b ena=%b, want busy=1 ena=0", busy, vram_wr_ena);
    end
    run_clear_check("dc_first", 100);
    @(negedge clk);
    total++;
    if (busy !== 1'b1 || vram_wr_ena !== 1'b0) begin
      bad++; $display("FAIL dc_enter2: got busy=%b ena=%b, want busy=1 ena=0", busy, vram_wr_ena);
    end
    run_clear_check("dc_second", -1);
  endtask

  task automatic test_reset_mid();
    send("rm_lift", 0, 20, 1'b0, 1'b1);
    send("rm_dot", 0, 20, 1'b1, 1'b1);
    touch_x = 9'd200; touch_y = 9'd20; touch_valid = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1; touch_valid = 1'b0;
    @(negedge clk);
    total++;
    if (vram_wr_ena !== 1'b0 || busy !== 1'b0 || vram_wr_addr !== '0) begin
      bad++; $display("FAIL rm_reset: got ena=%b busy=%b addr=%0d, want all 0", vram_wr_ena, busy, vram_wr_addr);
    end
    rst = 1'b0;
    run_clear_check("rm_clear", -1);
  endtask

  task automatic test_random();
    int x, y;
    bit v, e;
    for (int it = 0; it < 60; it++) begin
      v = ($urandom_range(0, 9) != 0);
      e = ($urandom_range(0, 7) != 0);
      if (pen && $urandom_range(0, 4) == 0) begin
        x = lx; y = ly;
      end else begin
        x = $urandom_range(0, 300);
        y = $urandom_range(0, 40);
      end
      send("rnd", x, y, v, e);
    end
  endtask

  initial begin
    test_reset();
    test_tap();
    test_back_to_back();
    test_diagonal();
    test_clamp_dup();
    test_clear_during_line();
    test_double_clear();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
